// File: rtl/trolley_system_button_debounce_ctrl.sv
// Trolley push-button controller: two-flop synchroniser, per-bit debounce,
// rising-edge capture and a PIO-compatible Avalon-MM register map with maskable irq.
module trolley_system_button_debounce_ctrl #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq,
    output logic [31:0]      readdata
);

    // Avalon-MM: a write happens on any cycle with chipselect high and write_n low;
    // readdata always reflects the address presented on the previous clock edge.

    typedef enum logic {
        DEB_STABLE   = 1'b0,
        DEB_SETTLING = 1'b1
    } deb_state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1, sync2;
    logic [WIDTH-1:0] deb, deb_next, rise;
    logic [WIDTH-1:0] irq_mask, mask_next;
    logic [WIDTH-1:0] edge_capture, ec_next, w1c;
    logic [CNT_W-1:0] cnt      [WIDTH];
    logic [CNT_W-1:0] cnt_next [WIDTH];
    deb_state_e       deb_state[WIDTH];
    logic [31:0]      rd_mux;
    logic             wr;
    logic             unused_writedata;

    assign unused_writedata = ^writedata;

    // Per-bit debounce: settling whenever the synchronised level disagrees
    // with the accepted one; a single agreeing cycle restarts the count.
    always_comb begin
        deb_next  = deb;
        cnt_next  = '{default: '0};
        deb_state = '{default: DEB_STABLE};
        for (int i = 0; i < WIDTH; i++) begin
            deb_state[i] = (sync2[i] != deb[i]) ? DEB_SETTLING : DEB_STABLE;
            if (deb_state[i] == DEB_SETTLING) begin
                if (cnt[i] == CNT_LAST) begin
                    deb_next[i] = sync2[i];
                end else begin
                    cnt_next[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // A new press sets its capture bit even if software clears it this cycle.
    always_comb begin
        wr        = chipselect & ~write_n;
        rise      = deb_next & ~deb;
        w1c       = (wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
        ec_next   = (edge_capture & ~w1c) | rise;
        mask_next = (wr && address == 2'd2) ? writedata[WIDTH-1:0] : irq_mask;
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            2'd0:    rd_mux[WIDTH-1:0] = deb;
            2'd2:    rd_mux[WIDTH-1:0] = irq_mask;
            2'd3:    rd_mux[WIDTH-1:0] = edge_capture;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1        <= '0;
            sync2        <= '0;
            deb          <= '0;
            irq_mask     <= '0;
            edge_capture <= '0;
            readdata     <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1        <= in_port;
            sync2        <= sync1;
            deb          <= deb_next;
            irq_mask     <= mask_next;
            edge_capture <= ec_next;
            readdata     <= rd_mux;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

    assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_trolley_system_button_debounce_ctrl.sv
// Bench for the trolley button controller: directed scenarios plus random
// stimulus, each cycle compared against a history-window reference model.
module tb_trolley_system_button_debounce_ctrl;

    localparam int W  = 4;
    localparam int DC = 4;

    logic        clk;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [W-1:0] in_port;
    logic        irq;
    logic [31:0] readdata;

    int n_total = 0;
    int n_bad   = 0;

    trolley_system_button_debounce_ctrl #(
        .WIDTH(W), .DEBOUNCE_CYCLES(DC), .CNT_W(4)
    ) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .irq(irq), .readdata(readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: sync pipeline as two delayed copies; a bit is accepted
    // once the last DC synchronised samples since reset all oppose its level.
    logic [W-1:0] m_s1 = '0, m_s2 = '0, m_deb = '0, m_mask = '0, m_ec = '0;
    logic [31:0]  m_rd = '0;
    logic [W-1:0] hist[$];

    task automatic model_update();
        logic [W-1:0] nd, rise, w1c;
        logic [31:0]  rd;
        bit           all_opp;
        if (reset) begin
            m_s1 = '0; m_s2 = '0; m_deb = '0; m_mask = '0; m_ec = '0; m_rd = '0;
            hist.delete();
        end else begin
            hist.push_back(m_s2);
            if (hist.size() > DC) void'(hist.pop_front());
            nd = m_deb;
            if (hist.size() == DC) begin
                for (int i = 0; i < W; i++) begin
                    all_opp = 1'b1;
                    for (int k = 0; k < DC; k++)
                        if (hist[k][i] == m_deb[i]) all_opp = 1'b0;
                    if (all_opp) nd[i] = ~m_deb[i];
                end
            end
            rise = nd & ~m_deb;
            w1c  = (chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : '0;
            rd   = '0;
            case (address)
                2'd0: rd[W-1:0] = m_deb;
                2'd2: rd[W-1:0] = m_mask;
                2'd3: rd[W-1:0] = m_ec;
                default: rd = '0;
            endcase
            m_ec = (m_ec & ~w1c) | rise;
            if (chipselect && !write_n && address == 2'd2) m_mask = writedata[W-1:0];
            m_rd  = rd;
            m_s2  = m_s1;
            m_s1  = in_port;
            m_deb = nd;
        end
    endtask

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check("model_rd", readdata, m_rd);
        check("model_irq", {31'b0, irq}, {31'b0, |(m_ec & m_mask)});
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        step();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a);
        address = a;
        step();
    endtask

    initial begin
        reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1;
        writedata = '0; in_port = '0;
        repeat (3) step();
        reset = 1'b0;
        bus_read(2'd0);
        check("reset_rd", readdata, 32'h0);
        check("reset_irq", {31'b0, irq}, 32'h0);

        // Clean press on bit 0: accepted on the 6th edge, visible in readdata one edge later.
        in_port = 4'b0001;
        address = 2'd0;
        repeat (6) step();
        check("lat0_pre", readdata, 32'h0);
        step();
        check("lat0_post", readdata, 32'h1);
        bus_read(2'd3);
        check("ec_press", readdata, 32'h1);
        check("irq_unmasked_off", {31'b0, irq}, 32'h0);

        // Masked interrupt, fresh press, W1C clear.
        bus_write(2'd3, 32'h1);
        in_port = 4'b0000;
        repeat (8) step();
        bus_write(2'd2, 32'h1);
        in_port = 4'b0001;
        repeat (5) step();
        check("irq_pre_accept", {31'b0, irq}, 32'h0);
        step();
        check("irq_accept", {31'b0, irq}, 32'h1);
        bus_write(2'd3, 32'h1);
        check("irq_w1c", {31'b0, irq}, 32'h0);
        bus_read(2'd3);
        check("ec_cleared", readdata, 32'h0);

        // Short glitch rejected, longer hold accepted.
        in_port = 4'b0011;
        repeat (3) step();
        in_port = 4'b0001;
        repeat (8) step();
        bus_read(2'd3);
        check("glitch_ec", readdata, 32'h0);
        bus_read(2'd0);
        check("glitch_deb", readdata, 32'h1);
        in_port = 4'b0011;
        repeat (5) step();
        in_port = 4'b0001;
        repeat (10) step();
        bus_read(2'd3);
        check("hold5_ec", readdata, 32'h2);

        // W1C landing on the accept edge of bit 2: set wins.
        bus_write(2'd2, 32'h4);
        in_port = 4'b0101;
        repeat (5) step();
        bus_write(2'd3, 32'h4);
        check("w1c_race_irq", {31'b0, irq}, 32'h1);
        bus_read(2'd3);
        check("w1c_race_ec", readdata, 32'h6);

        // Reset while bit 3 is mid-settle, then re-accept after release.
        in_port = 4'b0000;
        repeat (10) step();
        in_port = 4'b1000;
        repeat (4) step();
        reset = 1'b1;
        repeat (2) step();
        check("rst_mid_rd", readdata, 32'h0);
        check("rst_mid_irq", {31'b0, irq}, 32'h0);
        reset   = 1'b0;
        address = 2'd0;
        repeat (6) step();
        check("rearm_pre", readdata, 32'h0);
        step();
        check("rearm_post", readdata, 32'h8);
        bus_read(2'd3);
        check("rearm_ec", readdata, 32'h8);
        bus_read(2'd2);
        check("rearm_mask", readdata, 32'h0);

        // Random phase: bouncing inputs, random bus traffic, occasional reset.
        repeat (1500) begin
            for (int i = 0; i < W; i++)
                if ($urandom_range(0, 5) == 0) in_port[i] = ~in_port[i];
            address = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) begin
                chipselect = 1'b1;
                write_n    = 1'b0;
                writedata  = $urandom;
            end else begin
                chipselect = 1'($urandom_range(0, 1));
                write_n    = 1'b1;
            end
            reset = ($urandom_range(0, 299) == 0);
            step();
            chipselect = 1'b0;
            write_n    = 1'b1;
            reset      = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
